// File: rtl/ntt_pkg.sv
// Shared NTT constants, FSM state encoding and index helpers.
// Used by the coefficient bank and the butterfly address generators.
package ntt_pkg;

  localparam int ADDR_W = 6;
  localparam int LOG_N  = ADDR_W - 1;
  localparam int N      = 1 << LOG_N;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNLOAD
  } state_t;

  function automatic logic [LOG_N-1:0] bitrev(
    input logic [LOG_N-1:0] idx
  );
    logic [LOG_N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG_N; b++) begin
      r[b] = idx[LOG_N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_coeff_bank.sv
// NTT coefficient register bank: two read ports, per-word butterfly
// writes, and valid/ready load (bit-reversed) and unload streams.
module ntt_coeff_bank
  import ntt_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int DATA_WIDTH  = 32,
  parameter bit BITREV_LOAD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  input  logic [ADDR_WIDTH-1:0] waddr1_i,
  input  logic [ADDR_WIDTH-1:0] waddr2_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic [DATA_WIDTH-1:0] wdata2_i,
  input  logic [N-1:0]          we_i,
  input  logic                  load_start_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  input  logic                  unload_start_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  state_t state_q, state_d;

  logic [LOG_N-1:0] cnt;
  logic [LOG_N-1:0] cnt_inc;
  logic [LOG_N-1:0] load_idx;
  logic             load_hs;
  logic             unload_hs;
  logic             last;
  logic             done_d;

  logic [N-1:0][DATA_WIDTH-1:0] mem;
  logic [N-1:0][DATA_WIDTH-1:0] wval;
  logic [N-1:0]                 wen;

  // Top address bit selects nothing here; addresses wrap modulo N.
  logic unused_addr;
  assign unused_addr = ^{raddr1_i[ADDR_WIDTH-1:LOG_N],
                         raddr2_i[ADDR_WIDTH-1:LOG_N],
                         waddr1_i[ADDR_WIDTH-1:LOG_N],
                         waddr2_i[ADDR_WIDTH-1:LOG_N]};

  assign in_ready_o = (state_q == LOAD);
  assign busy_o     = (state_q != IDLE);
  assign load_hs    = (state_q == LOAD) && in_valid_i;
  assign unload_hs  = (state_q == UNLOAD) &&
                      out_valid_o && out_ready_i;
  assign last       = (cnt == {LOG_N{1'b1}});
  assign cnt_inc    = cnt + 1'b1;
  assign load_idx   = BITREV_LOAD ? bitrev(cnt) : cnt;

  // Port 1 takes priority when both addresses hit the same word.
  for (genvar i = 0; i < N; i++) begin : g_wsel
    logic hit1, hit2;
    assign hit1    = (waddr1_i[LOG_N-1:0] == LOG_N'(i));
    assign hit2    = (waddr2_i[LOG_N-1:0] == LOG_N'(i));
    assign wen[i]  = (state_q == IDLE) && we_i[i] &&
                     (hit1 || hit2);
    assign wval[i] = hit1 ? wdata1_i : wdata2_i;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
        end else if (unload_start_i) begin
          state_d = UNLOAD;
        end
      end
      LOAD: begin
        if (load_hs && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      UNLOAD: begin
        if (unload_hs && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem         <= '0;
      cnt         <= '0;
      rdata1_o    <= '0;
      rdata2_o    <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
    end else begin
      rdata1_o <= mem[raddr1_i[LOG_N-1:0]];
      rdata2_o <= mem[raddr2_i[LOG_N-1:0]];
      for (int i = 0; i < N; i++) begin
        if (wen[i]) begin
          mem[i] <= wval[i];
        end
      end
      if (state_q == IDLE && state_d != IDLE) begin
        cnt <= '0;
      end
      if (state_q == IDLE && state_d == UNLOAD) begin
        out_data_o  <= mem[0];
        out_valid_o <= 1'b1;
      end
      if (load_hs) begin
        mem[load_idx] <= in_data_i;
        cnt           <= cnt_inc;
      end
      if (unload_hs) begin
        if (last) begin
          out_valid_o <= 1'b0;
        end else begin
          cnt        <= cnt_inc;
          out_data_o <= mem[cnt_inc];
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_coeff_bank.sv
// Scoreboard bench for ntt_coeff_bank: stimulus queues expected
// read and unload data, monitors pop and compare on the falling edge.
module tb_ntt_coeff_bank;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] raddr1 = '0, raddr2 = '0;
  logic [DW-1:0] rdata1, rdata2;
  logic [AW-1:0] waddr1 = '0, waddr2 = '0;
  logic [DW-1:0] wdata1 = '0, wdata2 = '0;
  logic [NW-1:0] we = '0;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          unload_start = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          busy, done;

  ntt_coeff_bank #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BITREV_LOAD(1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raddr1_i      (raddr1),
    .raddr2_i      (raddr2),
    .rdata1_o      (rdata1),
    .rdata2_o      (rdata2),
    .waddr1_i      (waddr1),
    .waddr2_i      (waddr2),
    .wdata1_i      (wdata1),
    .wdata2_i      (wdata2),
    .we_i          (we),
    .load_start_i  (load_start),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_ready_o    (in_ready),
    .unload_start_i(unload_start),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_ready_i   (out_ready),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [DW-1:0] model [NW];
  logic [DW-1:0] out_q [$];
  logic [DW-1:0] rd_q  [$];
  logic          rd_req = 1'b0;
  logic          rd_arm;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_val = '0;

  task automatic check(input string nm,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rev5(input int i);
    logic [4:0] v, r;
    v = 5'(i);
    r = {<<{v}};
    return int'(r);
  endfunction

  // Read-port monitor: one-cycle latency from request to data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_arm <= 1'b0;
    else        rd_arm <= rd_req;
  end

  always @(negedge clk) begin
    if (rd_arm) begin
      if (rd_q.size() < 2) begin
        check("rd_underflow", 32'(rd_q.size()), 32'd2);
      end else begin
        check("rdata1", rdata1, rd_q.pop_front());
        check("rdata2", rdata2, rd_q.pop_front());
      end
    end
  end

  // Unload monitor: order, stall stability, done/busy exclusivity.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (out_valid) begin
        if (hold_pend) check("unl_hold", out_data, hold_val);
        if (out_ready) begin
          hold_pend = 1'b0;
          if (out_q.size() == 0)
            check("unl_extra", 32'd1, 32'd0);
          else
            check("unl_data", out_data, out_q.pop_front());
        end else begin
          hold_pend = 1'b1;
          hold_val  = out_data;
        end
      end else begin
        hold_pend = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic read_exp(input int a1, input int a2,
                          input logic [DW-1:0] e1,
                          input logic [DW-1:0] e2);
    raddr1 = AW'(a1);
    raddr2 = AW'(a2);
    rd_q.push_back(e1);
    rd_q.push_back(e2);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic read_model(input int a1, input int a2);
    read_exp(a1, a2, model[a1 % NW], model[a2 % NW]);
  endtask

  task automatic load_words(input int n, input int base,
                            input bit both, input int poke_at);
    @(posedge clk); #1;
    load_start   = 1'b1;
    unload_start = both;
    @(posedge clk); #1;
    load_start   = 1'b0;
    unload_start = 1'b0;
    check("ld_ready", 32'(in_ready), 32'd1);
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_no_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      if (i == poke_at) begin
        unload_start = 1'b1;
        we     = NW'(1) << 3;
        waddr1 = 6'd3;
        waddr2 = 6'd3;
        wdata1 = 32'hDEAD;
        wdata2 = 32'hBEEF;
      end
      @(posedge clk); #1;
      unload_start = 1'b0;
      we = '0;
      model[rev5(i)] = DW'(base + i);
    end
    in_valid = 1'b0;
    if (n == NW) begin
      @(negedge clk);
      check("ld_done", 32'(done), 32'd1);
      check("ld_done_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("ld_done_pulse", 32'(done), 32'd0);
      check("ld_idle_valid", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic unload_all(input bit toggle);
    int k;
    for (int i = 0; i < NW; i++) out_q.push_back(model[i]);
    @(posedge clk); #1;
    unload_start = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk); #1;
    unload_start = 1'b0;
    check("ul_valid", 32'(out_valid), 32'd1);
    check("ul_busy", 32'(busy), 32'd1);
    for (k = 0; k < 300; k++) begin
      out_ready = toggle ? ((k % 2) == 0) : 1'b1;
      @(posedge clk); #1;
      if (!out_valid) break;
    end
    if (k == 300) check("ul_timeout", 32'd1, 32'd0);
    check("ul_done", 32'(done), 32'd1);
    check("ul_left", 32'(out_q.size()), 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("ul_done_pulse", 32'(done), 32'd0);
    check("ul_valid_low", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    for (int i = 0; i < NW; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_exp(0, 31, 32'd0, 32'd0);

    load_words(NW, 100, 1'b0, -1);
    read_exp(1, 16, 32'd116, 32'd101);
    read_exp(31, 0, 32'd131, 32'd100);
    read_exp(33, 48, 32'd116, 32'd101);
    read_model(5, 22);

    unload_all(1'b1);

    // Butterfly write; same-cycle read returns the old words.
    waddr1 = 6'd3;
    waddr2 = 6'd19;
    wdata1 = 32'hAAAA;
    wdata2 = 32'h5555;
    we     = (NW'(1) << 3) | (NW'(1) << 19);
    read_exp(3, 19, 32'd124, 32'd125);
    we = '0;
    model[3]  = 32'hAAAA;
    model[19] = 32'h5555;
    read_exp(3, 19, 32'hAAAA, 32'h5555);

    waddr1 = 6'd7;
    waddr2 = 6'd7;
    wdata1 = 32'h1111;
    wdata2 = 32'h2222;
    we     = (NW'(1) << 7) | (NW'(1) << 8);
    @(posedge clk); #1;
    we = '0;
    model[7] = 32'h1111;
    read_exp(7, 8, 32'h1111, model[8]);

    // Wrapped write address: bit 5 ignored.
    waddr1 = 6'd41;
    waddr2 = 6'd0;
    wdata1 = 32'h3333;
    we     = NW'(1) << 9;
    @(posedge clk); #1;
    we = '0;
    model[9] = 32'h3333;
    read_model(9, 41);

    // Both starts together enter LOAD; poke during LOAD ignored.
    load_words(NW, 200, 1'b1, 30);
    read_exp(3, 0, 32'd224, 32'd200);
    read_model(19, 7);

    // Reset mid-load after ten words.
    dc = done_cnt;
    load_words(10, 500, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NW; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mr_no_done", 32'(done_cnt), 32'(dc));
    read_exp(0, 16, 32'd0, 32'd0);
    read_exp(3, 7, 32'd0, 32'd0);

    load_words(NW, 300, 1'b0, -1);
    read_exp(1, 31, 32'd316, 32'd331);
    unload_all(1'b0);

    repeat (2) @(posedge clk);
    check("done_total", 32'(done_cnt), 32'd5);
    check("rd_left", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
